// File: rtl/dsp_pkg.sv
// Shared definitions for the MAC engine: FSM states, register map and CTRL bit positions.
package dsp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StScale,
    StWrite,
    StFin
  } state_e;

  localparam logic [2:0] REG_BASE  = 3'd0;
  localparam logic [2:0] REG_LEN   = 3'd1;
  localparam logic [2:0] REG_COEF  = 3'd2;
  localparam logic [2:0] REG_SHIFT = 3'd3;
  localparam logic [2:0] REG_DST   = 3'd4;
  localparam logic [2:0] REG_CTRL  = 3'd5;

  localparam int unsigned CTRL_WB  = 0;
  localparam int unsigned CTRL_SAT = 1;

endpackage

// File: rtl/dsp_shift_sat.sv
// Arithmetic right shift of the accumulator down to result width, with optional clamping.
module dsp_shift_sat #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ACC_W  = 40
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic        [5:0]        shift_i,
  input  logic                     sat_en_i,
  output logic        [DATA_W-1:0] val_o,
  output logic                     ovf_o
);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc_i >>> shift_i;
    // In range only when every bit above the result sign bit matches it.
    ovf_o = ~((&shifted[ACC_W-1:DATA_W-1]) | ~(|shifted[ACC_W-1:DATA_W-1]));
    val_o = shifted[DATA_W-1:0];
    if (sat_en_i && ovf_o) begin
      val_o = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/dsp_mac_engine.sv
// Register-programmed MAC engine: streams LEN samples from RAM, multiplies by a signed gain,
// accumulates, scales/saturates the sum and optionally writes it back.
module dsp_mac_engine
  import dsp_pkg::*;
#(
  parameter int unsigned       DATA_W  = 24,
  parameter int unsigned       COEF_W  = 8,
  parameter int unsigned       ADDR_W  = 6,
  parameter int unsigned       ACC_W   = 40,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [2:0]        addr,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  output logic [ADDR_W-1:0] memaddr,
  output logic              memre,
  input  logic [DATA_W-1:0] memdout,
  output logic              memwe,
  output logic [DATA_W-1:0] memdin,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              sat
);

  state_e state_q, state_d;

  logic        [ADDR_W-1:0] base_q, base_d, dst_q, dst_d, j_dst_q, j_dst_d;
  logic        [ADDR_W:0]   len_q, len_d, cnt_q, cnt_d;
  logic        [COEF_W-1:0] coef_q, coef_d, j_coef_q, j_coef_d;
  logic        [5:0]        shift_q, shift_d, j_shift_q, j_shift_d;
  logic        [1:0]        ctrl_q, ctrl_d, j_ctrl_q, j_ctrl_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [ADDR_W-1:0] memaddr_q, memaddr_d;
  logic        [DATA_W-1:0] memdin_q, memdin_d, dout_q, dout_d;
  logic                     memre_q, memre_d, memwe_q, memwe_d, rd_vld_q, rd_vld_d, sat_q, sat_d;

  logic signed [ACC_W-1:0]  mem_ext, coef_ext;
  logic        [DATA_W-1:0] ss_val;
  logic                     ss_ovf;
  logic                     unused_din;

  assign unused_din = ^din;
  assign mem_ext    = ACC_W'($signed(memdout));
  assign coef_ext   = ACC_W'($signed(j_coef_q));

  dsp_shift_sat #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_shift_sat (
    .acc_i   (acc_q),
    .shift_i (j_shift_q),
    .sat_en_i(j_ctrl_q[CTRL_SAT]),
    .val_o   (ss_val),
    .ovf_o   (ss_ovf)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    coef_d    = coef_q;
    shift_d   = shift_q;
    dst_d     = dst_q;
    ctrl_d    = ctrl_q;
    j_coef_d  = j_coef_q;
    j_shift_d = j_shift_q;
    j_dst_d   = j_dst_q;
    j_ctrl_d  = j_ctrl_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    memaddr_d = memaddr_q;
    memdin_d  = memdin_q;
    dout_d    = dout_q;
    memre_d   = memre_q;
    memwe_d   = memwe_q;
    sat_d     = sat_q;
    // RAM data arrives one enabled cycle after the read strobe.
    rd_vld_d  = memre_q;
    if (rd_vld_q) begin
      acc_d = acc_q + mem_ext * coef_ext;
    end

    unique case (state_q)
      StIdle: begin
        if (we) begin
          case (addr)
            REG_BASE:  base_d  = din[ADDR_W-1:0];
            REG_LEN:   len_d   = din[ADDR_W:0];
            REG_COEF:  coef_d  = din[COEF_W-1:0];
            REG_SHIFT: shift_d = din[5:0];
            REG_DST:   dst_d   = din[ADDR_W-1:0];
            REG_CTRL:  ctrl_d  = din[1:0];
            default: ;
          endcase
        end
        if (start) begin
          j_coef_d  = coef_q;
          j_shift_d = shift_q;
          j_dst_d   = dst_q;
          j_ctrl_d  = ctrl_q;
          acc_d     = '0;
          sat_d     = 1'b0;
          if (len_q != '0) begin
            state_d   = StRead;
            memre_d   = 1'b1;
            memaddr_d = base_q;
            cnt_d     = len_q - (ADDR_W+1)'(1);
          end else begin
            state_d = StScale;
          end
        end
      end
      StRead: begin
        if (cnt_q == '0) begin
          memre_d = 1'b0;
          state_d = StDrain;
        end else begin
          memaddr_d = memaddr_q + ADDR_W'(1);
          cnt_d     = cnt_q - (ADDR_W+1)'(1);
        end
      end
      StDrain: state_d = StScale;
      StScale: begin
        dout_d = ss_val;
        sat_d  = j_ctrl_q[CTRL_SAT] & ss_ovf;
        if (j_ctrl_q[CTRL_WB]) begin
          memwe_d   = 1'b1;
          memaddr_d = j_dst_q;
          memdin_d  = ss_val;
          state_d   = StWrite;
        end else begin
          state_d = StFin;
        end
      end
      StWrite: begin
        memwe_d = 1'b0;
        state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      base_q    <= '0;
      len_q     <= '0;
      coef_q    <= '0;
      shift_q   <= '0;
      dst_q     <= '0;
      ctrl_q    <= '0;
      j_coef_q  <= '0;
      j_shift_q <= '0;
      j_dst_q   <= '0;
      j_ctrl_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      memaddr_q <= '0;
      memdin_q  <= '0;
      dout_q    <= RST_VAL;
      memre_q   <= 1'b0;
      memwe_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      sat_q     <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      coef_q    <= coef_d;
      shift_q   <= shift_d;
      dst_q     <= dst_d;
      ctrl_q    <= ctrl_d;
      j_coef_q  <= j_coef_d;
      j_shift_q <= j_shift_d;
      j_dst_q   <= j_dst_d;
      j_ctrl_q  <= j_ctrl_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      memaddr_q <= memaddr_d;
      memdin_q  <= memdin_d;
      dout_q    <= dout_d;
      memre_q   <= memre_d;
      memwe_q   <= memwe_d;
      rd_vld_q  <= rd_vld_d;
      sat_q     <= sat_d;
    end
  end

  assign memaddr = memaddr_q;
  assign memre   = memre_q & en;
  assign memwe   = memwe_q & en;
  assign memdin  = memdin_q;
  assign dout    = dout_q;
  assign sat     = sat_q;
  assign busy    = (state_q != StIdle) && (state_q != StFin);
  assign done    = (state_q == StFin);

endmodule

// File: tb/tb_dsp_mac_engine.sv
// Directed bench for dsp_mac_engine: a job-level model predicts every output cycle by cycle.
module tb_dsp_mac_engine;

  localparam int DW = 24;
  localparam int CW = 8;
  localparam int AW = 6;
  localparam int ACCW = 40;
  localparam logic [DW-1:0] RSTV = 24'h00A5A5;

  logic clk = 1'b0;
  logic rst, en, start, we;
  logic [2:0] addr;
  logic [DW-1:0] din, memdout, memdin, dout;
  logic [AW-1:0] memaddr;
  logic memre, memwe, busy, done, sat;

  always #5 clk = ~clk;

  dsp_mac_engine #(
    .DATA_W (DW),
    .COEF_W (CW),
    .ADDR_W (AW),
    .ACC_W  (ACCW),
    .RST_VAL(RSTV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (start),
    .addr   (addr),
    .din    (din),
    .we     (we),
    .memaddr(memaddr),
    .memre  (memre),
    .memdout(memdout),
    .memwe  (memwe),
    .memdin (memdin),
    .dout   (dout),
    .busy   (busy),
    .done   (done),
    .sat    (sat)
  );

  // Synchronous RAM with a bench-side poke port for preloading.
  logic [DW-1:0] ram [64];
  logic pk_we = 1'b0;
  logic [AW-1:0] pk_a = '0;
  logic [DW-1:0] pk_d = '0;
  always @(posedge clk) begin
    if (memre) memdout <= ram[memaddr];
    if (memwe) ram[memaddr] <= memdin;
    if (pk_we) ram[pk_a] <= pk_d;
  end

  int n_chk = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // ---------------- job-level model ----------------
  int m_base = 0, m_len = 0, m_coef = 0, m_shift = 0, m_dst = 0, m_ctrl = 0;
  bit m_act = 1'b0;
  int m_k = 0, m_fin = 0, m_jlen = 0, m_jbase = 0, m_jdst = 0;
  bit m_jwb = 1'b0, m_jsat = 1'b0, m_sat = 1'b0;
  logic [DW-1:0] m_res = '0, m_dout = RSTV;

  // Returns {sat, result} for a job using the current programmed config.
  function automatic logic [DW:0] model_job();
    longint s, r;
    logic [DW-1:0] v;
    logic sf;
    s = 0;
    for (int i = 0; i < m_len; i++)
      s += longint'($signed(ram[(m_base + i) % 64])) * longint'(m_coef);
    r = s >>> m_shift;
    sf = 1'b0;
    if (m_ctrl[1] && (r > 64'sd8388607 || r < -64'sd8388608)) begin
      v = (r < 0) ? 24'h800000 : 24'h7FFFFF;
      sf = 1'b1;
    end else begin
      v = r[DW-1:0];
    end
    return {sf, v};
  endfunction

  always @(posedge clk) begin
    logic [DW:0] jr;
    if (rst) begin
      m_act <= 1'b0; m_dout <= RSTV; m_sat <= 1'b0;
      m_base <= 0; m_len <= 0; m_coef <= 0; m_shift <= 0; m_dst <= 0; m_ctrl <= 0;
    end else if (en) begin
      if (m_act) begin
        if (m_k == m_fin) begin
          m_act <= 1'b0; m_dout <= m_res; m_sat <= m_jsat;
        end else m_k <= m_k + 1;
      end else begin
        if (start) begin
          jr = model_job();
          m_act <= 1'b1; m_k <= 1;
          m_jlen <= m_len; m_jbase <= m_base; m_jdst <= m_dst; m_jwb <= m_ctrl[0];
          m_res <= jr[DW-1:0]; m_jsat <= jr[DW];
          m_fin <= ((m_len == 0) ? 2 : m_len + 3) + int'(m_ctrl[0]);
        end
        if (we) begin
          case (addr)
            3'd0: m_base <= int'(din[5:0]);
            3'd1: m_len <= int'(din[6:0]);
            3'd2: m_coef <= int'($signed(din[7:0]));
            3'd3: m_shift <= int'(din[5:0]);
            3'd4: m_dst <= int'(din[5:0]);
            3'd5: m_ctrl <= int'(din[1:0]);
            default: ;
          endcase
        end
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      bit e_busy, e_done, e_re, e_we;
      e_busy = m_act && (m_k != m_fin);
      e_done = m_act && (m_k == m_fin);
      e_re = en && m_act && (m_k >= 1) && (m_k <= m_jlen);
      e_we = en && m_act && m_jwb && (m_k == m_fin - 1);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("memre", memre, e_re);
      chk("memwe", memwe, e_we);
      if (e_re) chk("rd_addr", memaddr, (m_jbase + m_k - 1) % 64);
      if (e_we) begin
        chk("wb_addr", memaddr, m_jdst);
        chk("wb_data", memdin, m_res);
      end
      if (e_done) begin
        chk("done_dout", dout, m_res);
        chk("done_sat", sat, m_jsat);
      end
      if (!m_act) begin
        chk("idle_dout", dout, m_dout);
        chk("idle_sat", sat, m_sat);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [DW-1:0] d);
    addr = a; din = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic poke(input int a, input logic [DW-1:0] d);
    pk_a = AW'(a); pk_d = d; pk_we = 1'b1;
    tick();
    pk_we = 1'b0;
  endtask

  task automatic start_job();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // n0: cycle offset from the start cycle at entry; leaves the bench in the cycle after done.
  task automatic wait_done(input string nm, input int n0, input int exp_n,
                           input logic [DW-1:0] exp_dout, input bit exp_sat);
    int n;
    n = n0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, n, exp_n);
    chk({nm, "_dout"}, dout, exp_dout);
    chk({nm, "_sat"}, sat, exp_sat);
    tick();
  endtask

  task automatic prog_a();
    wr(3'd0, 24'd4); wr(3'd1, 24'd3); wr(3'd2, 24'd3); wr(3'd3, 24'd1); wr(3'd5, 24'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; we = 1'b0; addr = '0; din = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_dout", dout, RSTV);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sat", sat, 1'b0);
    chk("rst_memre", memre, 1'b0);
    chk("rst_memwe", memwe, 1'b0);
    chk("rst_memaddr", memaddr, 0);
    chk("rst_memdin", memdin, 0);
    chk_on = 1'b1;

    // Basic: {10,-20,30}*3 = 60, >>>1 = 30.
    poke(4, 24'd10); poke(5, -24'sd20); poke(6, 24'd30);
    prog_a();
    start_job();
    chk("a_first_addr", memaddr, 4);
    wait_done("basic", 1, 6, 24'd30, 1'b0);

    // Saturation: 4 * 0x7FFFFF * 127 = 0xFDFFFE04.
    for (int i = 0; i < 4; i++) poke(i, 24'h7FFFFF);
    wr(3'd0, 24'd0); wr(3'd1, 24'd4); wr(3'd2, 24'd127); wr(3'd3, 24'd0); wr(3'd5, 24'd2);
    start_job();
    wait_done("sat_on", 1, 7, 24'h7FFFFF, 1'b1);
    wr(3'd5, 24'd0);
    start_job();
    wait_done("sat_off", 1, 7, 24'hFFFE04, 1'b0);

    // Writeback with address wrap: 62,63,0 -> (1+2+3)*2 = 12 to RAM[9].
    poke(62, 24'd1); poke(63, 24'd2); poke(0, 24'd3);
    wr(3'd0, 24'd62); wr(3'd1, 24'd3); wr(3'd2, 24'd2); wr(3'd4, 24'd9); wr(3'd5, 24'd1);
    start_job();
    wait_done("wb", 1, 7, 24'd12, 1'b0);
    chk("wb_ram9", ram[9], 24'd12);

    // Two-cycle stall mid-READ: done delayed by 2.
    prog_a();
    start_job();
    tick();
    en = 1'b0;
    tick(); tick();
    en = 1'b1;
    wait_done("stall", 4, 8, 24'd30, 1'b0);

    // Reset mid-job at T+2.
    start_job();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_memre", memre, 1'b0);
    chk("mid_rst_dout", dout, RSTV);
    chk("mid_rst_memaddr", memaddr, 0);
    chk("mid_rst_memdin", memdin, 0);
    repeat (8) tick();

    // COEF write while busy is dropped for this and later jobs.
    prog_a();
    start_job();
    wr(3'd2, 24'd7);
    wait_done("busy_wr", 2, 6, 24'd30, 1'b0);
    start_job();
    wait_done("busy_wr_next", 1, 6, 24'd30, 1'b0);

    // Write and start together: job uses COEF=2 (20), the next uses 5 (50).
    wr(3'd2, 24'd2);
    addr = 3'd2; din = 24'd5; we = 1'b1; start = 1'b1;
    tick();
    we = 1'b0; start = 1'b0;
    wait_done("same_cyc", 1, 6, 24'd20, 1'b0);
    start_job();
    wait_done("same_cyc_next", 1, 6, 24'd50, 1'b0);

    // Start while busy is ignored.
    start_job();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("start_busy", 3, 6, 24'd50, 1'b0);
    repeat (3) tick();
    chk("start_busy_idle", busy, 1'b0);

    // LEN=0 with writeback and saturate enabled.
    wr(3'd1, 24'd0); wr(3'd4, 24'd20); wr(3'd5, 24'd3);
    start_job();
    wait_done("len0", 1, 3, 24'd0, 1'b0);
    chk("len0_ram20", ram[20], 24'd0);

    // SHIFT beyond ACC_W leaves only sign bits: -60 >>> 63 = -1.
    wr(3'd1, 24'd3); wr(3'd2, 24'h0000FD); wr(3'd3, 24'd63); wr(3'd5, 24'd0);
    start_job();
    wait_done("bigshift", 1, 6, 24'hFFFFFF, 1'b0);

    repeat (2) tick();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
